// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern arbiter.
package led_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam int DEF_TICK_DIV = 500000;
  localparam int DEF_PAT_W    = 32;
  localparam int DEF_REP_W    = 4;
  localparam int HB_W         = 20;

  // Ceiling log2, never below 1 so a one-bit field is always legal.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1, pulses tick on the last count and
// pre_tick one cycle earlier. A synchronous clear restarts the count at 0.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);

  logic [CNT_W-1:0] cnt;

  // NOTE: flops are written with non-blocking assignments so every register
  // samples the pre-edge value of the others; reset is sampled on the edge.
  always_ff @(posedge CLK) begin
    if (!RST_N || clear) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick     = (cnt == CNT_LAST);
  assign pre_tick = (cnt == CNT_PRE);

endmodule

// File: rtl/led_pattern_arbiter.sv
// Round-robin owner of the single user LED: grants one requester at a time
// and plays its 32-step pattern r+1 times. Optional macro
// LED_IDLE_HEARTBEAT_EN shows a free-running heartbeat on the LED while idle.
module led_pattern_arbiter
  import led_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int PAT_W    = DEF_PAT_W,
  parameter int REP_W    = DEF_REP_W,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_REQ-1:0]         REQ_VALID,
  output logic [NUM_REQ-1:0]         REQ_READY,
  input  logic [NUM_REQ*PAT_W-1:0]   REQ_PATTERN,
  input  logic [NUM_REQ*REP_W-1:0]   REQ_REPEAT,
  output logic                       LED,
  output logic                       BUSY,
  output logic [clog2(NUM_REQ)-1:0]  ACTIVE_ID,
  output logic                       DONE
);

  localparam int ID_W   = clog2(NUM_REQ);
  localparam int STEP_W = clog2(PAT_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(PAT_W - 1);

  logic [PAT_W-1:0] pat_arr [NUM_REQ];
  logic [REP_W-1:0] rep_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign pat_arr[g] = REQ_PATTERN[g*PAT_W +: PAT_W];
    assign rep_arr[g] = REQ_REPEAT[g*REP_W +: REP_W];
  end

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand;
  logic              hs;
  logic              tick;
  logic              pre_tick;
  logic              idle_led;

  // Search starts just after the last granted requester.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && REQ_VALID[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign hs = RST_N && (state_q == IDLE) && grant_found;

  always_comb begin
    REQ_READY = '0;
    if (hs) REQ_READY[grant_idx] = 1'b1;
  end

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clear    (hs),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

`ifdef LED_IDLE_HEARTBEAT_EN
  logic [HB_W-1:0] hb_cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) hb_cnt <= '0;
    else        hb_cnt <= hb_cnt + 1'b1;
  end

  assign idle_led = hb_cnt[HB_W-1];
`else
  assign idle_led = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    rep_d    = rep_q;
    pat_d    = pat_q;
    led_d    = led_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        led_d  = idle_led;
        busy_d = 1'b0;
        step_d = '0;
        if (hs) begin
          state_d  = PLAY;
          pat_d    = pat_arr[grant_idx];
          rep_d    = rep_arr[grant_idx];
          id_d     = grant_idx;
          rr_ptr_d = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
          led_d    = pat_arr[grant_idx][0];
          busy_d   = 1'b1;
        end
      end
      PLAY: begin
        // Registered DONE must be set one cycle ahead of the final cycle.
        done_d = (step_q == LAST_STEP) && (rep_q == '0) && pre_tick;
        if (tick) begin
          if (step_q == LAST_STEP) begin
            step_d = '0;
            if (rep_q != '0) begin
              rep_d = rep_q - 1'b1;
              led_d = pat_q[0];
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              led_d   = idle_led;
            end
          end else begin
            step_d = step_q + 1'b1;
            led_d  = pat_q[step_q + 1'b1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the latched pattern and repeat count are plain flops, not a memory
  // array, so they are reset along with the rest to keep state deterministic.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      step_q   <= '0;
      rep_q    <= '0;
      pat_q    <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      rep_q    <= rep_d;
      pat_q    <= pat_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign LED       = led_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ACTIVE_ID = id_q;

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Self-checking bench for led_pattern_arbiter: directed scenarios plus random
// traffic, all compared every cycle against a cycle-count reference model.
module tb_led_pattern_arbiter;

  localparam int NR = 4;
  localparam int PW = 32;
  localparam int RW = 4;
  localparam int TD = 4;

  logic              CLK;
  logic              RST_N;
  logic [NR-1:0]     REQ_VALID;
  logic [NR-1:0]     REQ_READY;
  logic [NR*PW-1:0]  REQ_PATTERN;
  logic [NR*RW-1:0]  REQ_REPEAT;
  logic              LED;
  logic              BUSY;
  logic [1:0]        ACTIVE_ID;
  logic              DONE;

  led_pattern_arbiter #(
    .NUM_REQ  (NR),
    .PAT_W    (PW),
    .REP_W    (RW),
    .TICK_DIV (TD)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .REQ_PATTERN (REQ_PATTERN),
    .REQ_REPEAT  (REQ_REPEAT),
    .LED         (LED),
    .BUSY        (BUSY),
    .ACTIVE_ID   (ACTIVE_ID),
    .DONE        (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a grant plays for (r+1)*PW*TD cycles counted from the
  // cycle after the handshake; the LED shows bit (k/TD)%PW of the pattern.
  bit          m_play    = 1'b0;
  int          m_k       = 0;
  int          m_len     = 0;
  logic [31:0] m_pat     = '0;
  int          m_id      = 0;
  int          m_ptr     = 0;
  logic [NR-1:0] rdy_seen = '0;
  int          glog[$];

  always @(negedge CLK) begin
    logic [NR-1:0] e_rdy;
    bit            found;
    int            g;
    e_rdy = '0;
    found = 1'b0;
    g     = 0;
    if (RST_N && !m_play) begin
      for (int i = 0; i < NR; i++) begin
        int idx;
        idx = (m_ptr + i) % NR;
        if (!found && REQ_VALID[idx]) begin
          found = 1'b1;
          g = idx;
          e_rdy[idx] = 1'b1;
        end
      end
    end

    check("ready", REQ_READY, e_rdy);
    check("busy", BUSY, m_play);
    check("led", LED, m_play ? m_pat[(m_k / TD) % PW] : 1'b0);
    check("done", DONE, m_play && (m_k == m_len - 1));
    check("active_id", ACTIVE_ID, m_id);

    rdy_seen = REQ_READY;
    for (int i = 0; i < NR; i++) if (REQ_READY[i]) glog.push_back(i);

    if (!RST_N) begin
      m_play = 1'b0;
      m_ptr  = 0;
      m_id   = 0;
    end else if (m_play) begin
      m_k++;
      if (m_k == m_len) m_play = 1'b0;
    end else if (found) begin
      m_play = 1'b1;
      m_k    = 0;
      m_pat  = REQ_PATTERN[g*PW +: PW];
      m_len  = (int'(REQ_REPEAT[g*RW +: RW]) + 1) * PW * TD;
      m_id   = g;
      m_ptr  = (g + 1) % NR;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] p, input logic [3:0] r, input logic v);
    REQ_PATTERN[i*PW +: PW] = p;
    REQ_REPEAT[i*RW +: RW]  = r;
    REQ_VALID[i]            = v;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while (BUSY !== 1'b0 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    check("idle_within_bound", (n < 5000), 1);
  endtask

  initial begin
    logic [3:0] led_exp;
    int busy_n, done_n, n, ones;
    int exp_order[5];

    RST_N       = 1'b0;
    REQ_VALID   = '0;
    REQ_PATTERN = '0;
    REQ_REPEAT  = '0;

    // Reset held three cycles with nothing requested.
    step(3);
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst_led", LED, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_ready", REQ_READY, 0);
    step(1);

    // Requester 2, pattern 0x5, single play.
    set_req(2, 32'h0000_0005, 4'd0, 1'b1);
    #1;
    check("req2_ready", REQ_READY, 4'b0100);
    step(1);
    REQ_VALID[2] = 1'b0;
    led_exp = 4'b0101;
    @(negedge CLK);
    check("req2_busy", BUSY, 1);
    check("req2_id", ACTIVE_ID, 2);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) repeat (TD) @(negedge CLK);
      check("req2_led_step", LED, led_exp[j]);
    end
    repeat (115) @(negedge CLK);
    check("req2_done_at_128", DONE, 1);
    @(negedge CLK);
    check("req2_busy_low_129", BUSY, 0);
    check("req2_led_low_129", LED, 0);
    step(1);

    // Requester 1, all-ones, three plays.
    set_req(1, 32'hFFFF_FFFF, 4'd2, 1'b1);
    step(1);
    REQ_VALID[1] = 1'b0;
    busy_n = 0;
    done_n = 0;
    n = 0;
    @(negedge CLK);
    while (BUSY === 1'b1 && n < 1000) begin
      busy_n++;
      if (DONE === 1'b1) done_n++;
      @(negedge CLK);
      n++;
    end
    check("req1_busy_cycles", busy_n, 384);
    check("req1_done_pulses", done_n, 1);
    step(1);

    // Round-robin after reset: 0 beats 3, then 3, then 0,1,2,3,0.
    RST_N = 1'b0;
    step(1);
    RST_N = 1'b1;
    set_req(0, 32'h0F0F_00FF, 4'd0, 1'b1);
    set_req(3, 32'hA5A5_5A5A, 4'd0, 1'b1);
    #1;
    check("rr_first_ready", REQ_READY, 4'b0001);
    step(1);
    REQ_VALID[0] = 1'b0;
    @(negedge CLK);
    check("rr_first_id", ACTIVE_ID, 0);
    wait_idle();
    check("rr_second_ready", REQ_READY, 4'b1000);
    step(1);
    REQ_VALID[3] = 1'b0;
    wait_idle();
    step(1);
    set_req(1, 32'h8000_0001, 4'd0, 1'b1);
    set_req(2, 32'h3C3C_C3C3, 4'd0, 1'b1);
    REQ_VALID = 4'hF;
    glog.delete();
    n = 0;
    while (glog.size() < 5 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    step(1);
    REQ_VALID = '0;
    exp_order = '{0, 1, 2, 3, 0};
    check("rr_grant_count", glog.size(), 5);
    for (int j = 0; j < 5 && j < glog.size(); j++) check("rr_grant_order", glog[j], exp_order[j]);
    wait_idle();
    step(1);

    // Reset in the middle of step 10 of requester 0.
    set_req(0, 32'h1234_5678, 4'd3, 1'b1);
    step(1);
    REQ_VALID[0] = 1'b0;
    step(40);
    RST_N = 1'b0;
    step(1);
    RST_N = 1'b1;
    @(negedge CLK);
    check("abort_led", LED, 0);
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    check("abort_id", ACTIVE_ID, 0);
    step(1);
    REQ_VALID[0] = 1'b1;
    #1;
    check("regrant_ready", REQ_READY, 4'b0001);
    step(1);
    REQ_VALID[0] = 1'b0;
    @(negedge CLK);
    check("regrant_busy", BUSY, 1);
    set_req(0, 32'h0000_FFFF, 4'd0, 1'b0);
    wait_idle();
    step(1);

    // Requester 1 withdraws while requester 0 plays.
    glog.delete();
    set_req(0, 32'hF00F_0FF0, 4'd0, 1'b1);
    step(1);
    REQ_VALID[0] = 1'b0;
    REQ_VALID[1] = 1'b1;
    step(20);
    REQ_VALID[1] = 1'b0;
    wait_idle();
    step(5);
    ones = 0;
    foreach (glog[j]) if (glog[j] == 1) ones++;
    check("withdrawn_never_granted", ones, 0);
    REQ_VALID[2] = 1'b1;
    #1;
    check("no_stall_ready", REQ_READY, 4'b0100);
    step(1);
    REQ_VALID[2] = 1'b0;
    wait_idle();
    step(1);

    // Random traffic, including withdrawals and occasional resets.
    for (int c = 0; c < 5000; c++) begin
      logic [NR-1:0] hs_prev;
      hs_prev = rdy_seen & REQ_VALID;
      RST_N = ($urandom_range(0, 1499) != 0);
      for (int i = 0; i < NR; i++) begin
        if (REQ_VALID[i] && hs_prev[i]) begin
          if ($urandom_range(0, 1) == 0) REQ_VALID[i] = 1'b0;
          else set_req(i, $urandom, 4'($urandom_range(0, 2)), 1'b1);
        end else if (REQ_VALID[i]) begin
          if ($urandom_range(0, 63) == 0) REQ_VALID[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          set_req(i, $urandom, 4'($urandom_range(0, 2)), 1'b1);
        end
      end
      step(1);
    end
    RST_N = 1'b1;
    REQ_VALID = '0;
    wait_idle();
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_pattern_arbiter.md
# led_pattern_arbiter

Shares the board's single user LED between several on-chip requesters, each submitting a 32-step blink pattern with a repeat count. A round-robin arbiter grants one request at a time; a prescaled tick steps through the granted pattern bit by bit and drives LED. It sits between the status-producing blocks and the LED pin, replacing a free-running counter tap as the LED driver.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- PAT_W, 32: pattern length in steps
- REP_W, 4: repeat-count width
- TICK_DIV, 500000: CLK cycles per pattern step (16 MHz → 32 steps/s); minimum 2
- CLK  in  1  16 MHz system clock, all logic on rising edge
- RST_N  in  1  reset; synchronous and active-low
- REQ_VALID  in  NUM_REQ  per-requester request valid
- REQ_READY  out  NUM_REQ  per-requester grant; one-hot or zero
- REQ_PATTERN  in  NUM_REQ*PAT_W  pattern of requester i at [i*PAT_W +: PAT_W]; bit 0 played first
- REQ_REPEAT  in  NUM_REQ*REP_W  repeat count r of requester i; pattern plays r+1 times
- LED  out  1  LED drive, registered
- BUSY  out  1  high while a pattern is playing
- ACTIVE_ID  out  clog2(NUM_REQ)  index of requester being played
- DONE  out  1  one-cycle pulse on final cycle of a pattern's last repeat

## Operation
- States: IDLE, PLAY.
- IDLE: if any REQ_VALID, REQ_READY asserts combinationally for exactly one requester selected round-robin; handshake = VALID & READY in the same cycle. Pattern, repeat count and index latched on handshake; next state PLAY.
- Round-robin: priority starts at index last_grant+1 (mod NUM_REQ); after reset, requester 0 highest.
- Requester holds VALID and data stable until handshake; dropping VALID before grant withdraws the request, no error.
- PLAY: LED = pattern[step]; step advances every TICK_DIV cycles. At step PAT_W-1 with repeat counter > 0: step wraps to 0, counter decrements. At step PAT_W-1 with counter = 0: DONE pulses on that step's final cycle, next state IDLE.
- REQ_READY is all-zero in PLAY; new requests wait, not queued internally.
- Reset (any time, incl. mid-PLAY): state IDLE, LED 0, BUSY 0, ACTIVE_ID 0, DONE 0, REQ_READY 0, step 0, prescaler 0, round-robin pointer to requester 0. Aborted pattern produces no DONE.
- Counters: step is clog2(PAT_W) bits, wraps only as above; prescaler counts 0..TICK_DIV-1 and clears on handshake.

## Timing
- Handshake in cycle T → cycle T+1: BUSY=1, ACTIVE_ID valid, LED=pattern[0].
- Each step lasts exactly TICK_DIV cycles; a grant plays for (r+1)*PAT_W*TICK_DIV cycles, BUSY high throughout.
- DONE high in last PLAY cycle; BUSY and LED low the following cycle (IDLE); earliest next handshake that same IDLE cycle, so one-cycle minimum LED gap between patterns.
- REQ_READY is combinational from state, pointer and REQ_VALID; all other outputs registered.

## Configuration
- LED_IDLE_HEARTBEAT_EN defined: in IDLE, LED follows a free-running heartbeat (bit 19 of a 20-bit counter clocked by CLK, reset to 0), so the board visibly blinks with no requests; counter runs through PLAY but is not shown.
- Not defined: LED is 0 in IDLE; heartbeat counter absent.

## Structure
- Shared package led_pkg: state enum (IDLE, PLAY), default TICK_DIV, PAT_W, REP_W constants, clog2 helper function.
- One sub-module: led_tick_gen (prescaler with synchronous clear, outputs one-cycle tick every TICK_DIV cycles).

## Test plan (TICK_DIV=4, PAT_W=32, NUM_REQ=4)
- Reset held 3 cycles, no requests → LED, BUSY, DONE, REQ_READY all 0; with LED_IDLE_HEARTBEAT_EN, LED rises after 2^19 cycles.
- Req 2 valid, pattern 0x0000_0005, r=0 → READY[2] same cycle; LED 1 for 4 cycles, 0 for 4, 1 for 4, then 0; DONE at cycle 128 after grant; BUSY low cycle 129.
- Req 1, pattern 0xFFFF_FFFF, r=2 → BUSY high exactly 384 cycles, single DONE pulse.
- Reqs 0 and 3 valid simultaneously after reset → grant 0, then 3; with all four continuously valid grant order 0,1,2,3,0.
- Req 0 granted, RST_N low at step 10 → next cycle all outputs reset, no DONE; re-request is granted normally.
- Req 1 drops VALID before grant while req 0 plays → req 1 never granted, no stall.
